swing_scheduler: RTL and testbench

Round-robin scheduler that shares one sultans_of_swing datapath (registered Ao/Bo plus ANDo = (A^B)&C, 1-cycle latency) between NUM_REQ requesters. Valid/ready request handshake per requester. Operands are registered onto the datapath, results are tagged with the requester ID, and results are buffered in a credit-protected response FIFO. Sits between hashing-stage clients and the shared datapath instance.

---
 rtl/sos_pkg.sv | 39 +++
 rtl/swing_scheduler_if.sv | 34 +++
 rtl/swing_rsp_fifo.sv | 68 ++++++
 rtl/swing_scheduler.sv | 113 +++++++++++
 tb/tb_swing_scheduler.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sos_pkg.sv
// Shared types, constants and the round-robin pick helper for the swing scheduler slice.
package sos_pkg;

    localparam int unsigned SOS_W         = 4;
    localparam int unsigned SOS_DP_LAT    = 1;
    localparam int unsigned SOS_SCHED_LAT = 3;
    localparam int unsigned SOS_MAX_REQ   = 8;
    localparam int unsigned SOS_ID_W      = 3;

    typedef struct packed {
        logic [SOS_ID_W-1:0] id;
        logic [SOS_W-1:0]    a;
        logic [SOS_W-1:0]    b;
        logic [SOS_W-1:0]    and_r;
    } sos_rsp_t;

    typedef struct packed {
        logic                hit;
        logic [SOS_ID_W-1:0] idx;
    } sos_pick_t;

    // First set bit of eligible searching upward from ptr+1, wrapping at n.
    function automatic sos_pick_t rr_pick(input logic [SOS_MAX_REQ-1:0] eligible,
                                          input logic [SOS_ID_W-1:0]    ptr,
                                          input int unsigned            n);
        sos_pick_t   r;
        int unsigned k;
        r = '0;
        for (int unsigned i = 1; i <= SOS_MAX_REQ; i++) begin
            k = (32'(ptr) + i) % n;
            if (i <= n && !r.hit && eligible[SOS_ID_W'(k)]) begin
                r.hit = 1'b1;
                r.idx = SOS_ID_W'(k);
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/swing_scheduler_if.sv
// Request, datapath and response bundle between clients and the swing scheduler.
interface swing_scheduler_if #(
    parameter int unsigned W       = 4,
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDW     = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*W-1:0] req_a;
    logic [NUM_REQ*W-1:0] req_b;
    logic [NUM_REQ*W-1:0] req_c;
    logic [W-1:0]         dp_a;
    logic [W-1:0]         dp_b;
    logic [W-1:0]         dp_c;
    logic [W-1:0]         dp_ao;
    logic [W-1:0]         dp_bo;
    logic [W-1:0]         dp_ando;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [W-1:0]         rsp_a;
    logic [W-1:0]         rsp_b;
    logic [W-1:0]         rsp_and;

    modport master (
        output req_valid, req_a, req_b, req_c, rsp_ready, dp_ao, dp_bo, dp_ando,
        input  req_ready, dp_a, dp_b, dp_c, rsp_valid, rsp_id, rsp_a, rsp_b, rsp_and
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c, rsp_ready, dp_ao, dp_bo, dp_ando,
        output req_ready, dp_a, dp_b, dp_c, rsp_valid, rsp_id, rsp_a, rsp_b, rsp_and
    );
endinterface

// File: rtl/swing_rsp_fifo.sv
// Response FIFO with a registered head that holds its last value while empty.
module swing_rsp_fifo
    import sos_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  sos_rsp_t               push_data,
    input  logic                   pop,
    output logic                   valid,
    output sos_rsp_t               head,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    sos_rsp_t      mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_pop;
    logic [CW-1:0] count_n;

    always_comb begin
        do_pop  = pop && valid;
        count_n = count + CW'(push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head is refreshed from the incoming entry when it becomes the oldest one.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= 1'b0;
            head   <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_n;
            valid <= (count_n != '0);
            if (count_n != '0) begin
                if (!valid || (do_pop && count == CW'(1))) begin
                    head <= push_data;
                end else if (do_pop) begin
                    head <= mem[rd_ptr + 1'b1];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            assert (!(push && count == CW'(DEPTH)));
        end
    end
endmodule

// File: rtl/swing_scheduler.sv
// Round-robin arbiter sharing one sultans_of_swing datapath, with credit-protected tagged responses.
module swing_scheduler
    import sos_pkg::*;
#(
    parameter int unsigned W          = SOS_W,
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned IDW        = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cfg_enable,
    input  logic [NUM_REQ-1:0] cfg_mask,
    swing_scheduler_if.slave   bus,
    output logic               busy
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic [NUM_REQ-1:0] eligible;
    logic [1:0]         inflight;
    logic               can_issue;
    logic               accept;
    sos_pick_t          pick;
    logic [IDW-1:0]     grant_id;
    logic [W-1:0]       op_a;
    logic [W-1:0]       op_b;
    logic [W-1:0]       op_c;
    logic [IDW-1:0]     ptr;
    logic               s1_v;
    logic [IDW-1:0]     s1_id;
    logic               s2_v;
    logic [IDW-1:0]     s2_id;
    logic [CW-1:0]      fifo_count;
    logic               fifo_valid;
    sos_rsp_t           push_data;
    sos_rsp_t           head;

    // Grant selection: credit covers both FIFO occupancy and results still in the pipe.
    always_comb begin
        eligible      = bus.req_valid & ~cfg_mask;
        inflight      = {1'b0, s1_v} + {1'b0, s2_v};
        can_issue     = cfg_enable && ((32'(fifo_count) + 32'(inflight)) < FIFO_DEPTH);
        pick          = rr_pick(SOS_MAX_REQ'(eligible), SOS_ID_W'(ptr), NUM_REQ);
        accept        = can_issue && pick.hit;
        grant_id      = IDW'(pick.idx);
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[grant_id] = 1'b1;
        end
        op_a = '0;
        op_b = '0;
        op_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (bus.req_ready[i]) begin
                op_a = bus.req_a[i*W +: W];
                op_b = bus.req_b[i*W +: W];
                op_c = bus.req_c[i*W +: W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.dp_a <= '0;
            bus.dp_b <= '0;
            bus.dp_c <= '0;
            s1_v     <= 1'b0;
            s1_id    <= '0;
            s2_v     <= 1'b0;
            s2_id    <= '0;
            ptr      <= IDW'(NUM_REQ - 1);
        end else begin
            s1_v  <= accept;
            s2_v  <= s1_v;
            s2_id <= s1_id;
            if (accept) begin
                bus.dp_a <= op_a;
                bus.dp_b <= op_b;
                bus.dp_c <= op_c;
                s1_id    <= grant_id;
                ptr      <= grant_id;
            end
        end
    end

    // Stage 2 lines up with the datapath outputs for the operands issued two cycles earlier.
    always_comb begin
        push_data = '{id:    SOS_ID_W'(s2_id),
                      a:     SOS_W'(bus.dp_ao),
                      b:     SOS_W'(bus.dp_bo),
                      and_r: SOS_W'(bus.dp_ando)};
    end

    swing_rsp_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (s2_v),
        .push_data (push_data),
        .pop       (bus.rsp_ready),
        .valid     (fifo_valid),
        .head      (head),
        .count     (fifo_count)
    );

    assign bus.rsp_valid = fifo_valid;
    assign bus.rsp_id    = IDW'(head.id);
    assign bus.rsp_a     = W'(head.a);
    assign bus.rsp_b     = W'(head.b);
    assign bus.rsp_and   = W'(head.and_r);
    assign busy          = s1_v || s2_v || fifo_valid;
endmodule

// File: tb/tb_swing_scheduler.sv
// Randomized and directed bench for swing_scheduler against a transaction-level queue model.
module tb_swing_scheduler;
    import sos_pkg::*;

    localparam int unsigned W     = 4;
    localparam int unsigned NR    = 4;
    localparam int unsigned IDW   = 2;
    localparam int unsigned DEPTH = 4;

    typedef struct {
        int id;
        int a;
        int b;
        int andv;
        int vis;
    } item_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          cfg_enable = 1'b0;
    logic [NR-1:0] cfg_mask = '0;
    logic          busy;

    swing_scheduler_if #(.W(W), .NUM_REQ(NR), .IDW(IDW)) bus ();

    swing_scheduler #(.W(W), .NUM_REQ(NR), .IDW(IDW), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_enable (cfg_enable),
        .cfg_mask   (cfg_mask),
        .bus        (bus),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the shared datapath: registered Ao/Bo and (A^B)&C.
    always @(posedge clk) begin
        bus.dp_ao   <= bus.dp_a;
        bus.dp_bo   <= bus.dp_b;
        bus.dp_ando <= (bus.dp_a ^ bus.dp_b) & bus.dp_c;
    end

    logic [W-1:0]  op_a [NR];
    logic [W-1:0]  op_b [NR];
    logic [W-1:0]  op_c [NR];
    logic [NR-1:0] v_valid;

    item_t q[$];
    item_t rlog[$];
    int    glog[$];
    int    cyc;
    int    ptr;
    int    dpa, dpb, dpc;
    item_t last;
    bit    started;
    int    checks;
    int    errors;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic apply();
        bus.req_valid = v_valid;
        for (int i = 0; i < NR; i++) begin
            bus.req_a[i*W +: W] = op_a[i];
            bus.req_b[i*W +: W] = op_b[i];
            bus.req_c[i*W +: W] = op_c[i];
        end
    endtask

    task automatic model_reset();
        q.delete();
        ptr  = NR - 1;
        dpa  = 0;
        dpb  = 0;
        dpc  = 0;
        last = '{0, 0, 0, 0, 0};
    endtask

    // One clock: check at negedge, then advance the model with what the DUT sees at posedge.
    task automatic tick();
        int    g;
        int    obs;
        int    idx;
        bit    vexp;
        bit    can;
        item_t it;
        g    = -1;
        obs  = -1;
        vexp = 1'b0;
        @(negedge clk);
        if (started) begin
            if (reset) begin
                can = cfg_enable && (q.size() < DEPTH);
                for (int k = 1; k <= NR; k++) begin
                    idx = (ptr + k) % NR;
                    if (g < 0 && can && bus.req_valid[idx] && !cfg_mask[idx]) g = idx;
                end
                chk("req_ready", 32'(bus.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
                for (int i = 0; i < NR; i++) begin
                    if (bus.req_ready[i] && bus.req_valid[i]) obs = i;
                end
            end
            vexp = (q.size() > 0) && (q[0].vis <= cyc);
            if (vexp) last = q[0];
            chk("rsp_valid", 32'(bus.rsp_valid), 32'(vexp));
            chk("rsp_id", 32'(bus.rsp_id), last.id);
            chk("rsp_a", 32'(bus.rsp_a), last.a);
            chk("rsp_b", 32'(bus.rsp_b), last.b);
            chk("rsp_and", 32'(bus.rsp_and), last.andv);
            chk("busy", 32'(busy), 32'(q.size() != 0));
            chk("dp_a", 32'(bus.dp_a), dpa);
            chk("dp_b", 32'(bus.dp_b), dpb);
            chk("dp_c", 32'(bus.dp_c), dpc);
            if (obs >= 0) glog.push_back(obs);
            if (bus.rsp_valid && bus.rsp_ready) begin
                it = '{int'(bus.rsp_id), int'(bus.rsp_a), int'(bus.rsp_b), int'(bus.rsp_and), cyc};
                rlog.push_back(it);
            end
        end
        @(posedge clk);
        if (!reset) begin
            model_reset();
        end else begin
            if (vexp && bus.rsp_ready) void'(q.pop_front());
            if (g >= 0) begin
                it.id   = g;
                it.a    = int'(op_a[g]);
                it.b    = int'(op_b[g]);
                it.andv = int'((op_a[g] ^ op_b[g]) & op_c[g]);
                it.vis  = cyc + SOS_SCHED_LAT;
                q.push_back(it);
                ptr = g;
                dpa = it.a;
                dpb = it.b;
                dpc = int'(op_c[g]);
            end
        end
        started = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic drain();
        int n;
        v_valid       = '0;
        bus.rsp_ready = 1'b1;
        apply();
        n = 0;
        while (busy !== 1'b0 && n < 30) begin
            tick();
            n++;
        end
        if (n >= 30) chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    task automatic rand_ops();
        for (int i = 0; i < NR; i++) begin
            op_a[i] = W'($urandom);
            op_b[i] = W'($urandom);
            op_c[i] = W'($urandom);
        end
    endtask

    int n0;
    int r0;
    int cnt;
    int exp_order [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        started       = 1'b0;
        bus.rsp_ready = 1'b0;
        v_valid       = '0;
        rand_ops();
        apply();
        model_reset();

        // Reset held for two cycles, then a single request from requester 2.
        reset = 1'b0;
        tick();
        tick();
        reset      = 1'b1;
        cfg_enable = 1'b1;
        op_a[2]    = 4'd3;
        op_b[2]    = 4'd6;
        op_c[2]    = 4'd1;
        v_valid    = 4'b0100;
        apply();
        #1;
        chk("t1_ready", 32'(bus.req_ready), 32'h4);
        tick();
        v_valid = '0;
        apply();
        tick();
        tick();
        chk("t1_valid", 32'(bus.rsp_valid), 32'd1);
        chk("t1_id", 32'(bus.rsp_id), 32'd2);
        chk("t1_a", 32'(bus.rsp_a), 32'd3);
        chk("t1_b", 32'(bus.rsp_b), 32'd6);
        chk("t1_and", 32'(bus.rsp_and), 32'd1);

        // Round robin from a fresh reset with everyone requesting.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        rand_ops();
        v_valid       = '1;
        bus.rsp_ready = 1'b1;
        apply();
        n0 = glog.size();
        r0 = rlog.size();
        repeat (6) tick();
        drain();
        for (int i = 0; i < 6; i++) begin
            chk("rr_grant", 32'(glog[n0+i]), 32'(exp_order[i]));
            chk("rr_rsp", 32'(rlog[r0+i].id), 32'(exp_order[i]));
        end

        // Backpressure: credit stops grants at FIFO_DEPTH outstanding.
        v_valid       = '1;
        bus.rsp_ready = 1'b0;
        apply();
        n0 = glog.size();
        r0 = rlog.size();
        repeat (10) tick();
        chk("bp_grants", 32'(glog.size() - n0), DEPTH);
        chk("bp_ready", 32'(bus.req_ready), 32'd0);
        bus.rsp_ready = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 4; i++) chk("bp_order", 32'(rlog[r0+i].id), 32'(glog[n0+i]));
        chk("bp_resume", 32'(glog.size() > n0 + 4), 32'd1);
        drain();

        // Masked requester is never granted.
        cfg_mask = 4'b0010;
        v_valid  = '1;
        apply();
        n0 = glog.size();
        for (int i = 0; i < 24; i++) begin
            bus.rsp_ready = 1'($urandom);
            tick();
        end
        cnt = 0;
        for (int i = n0; i < glog.size(); i++) if (glog[i] == 1) cnt++;
        chk("mask_r1", 32'(cnt), 32'd0);
        cfg_mask = '0;
        drain();

        // Enable dropped with two in flight: they still complete.
        r0            = rlog.size();
        v_valid       = '1;
        bus.rsp_ready = 1'b1;
        apply();
        tick();
        tick();
        cfg_enable = 1'b0;
        n0 = glog.size();
        cnt = 0;
        while (busy !== 1'b0 && cnt < 12) begin
            tick();
            cnt++;
        end
        chk("en_grants", 32'(glog.size() - n0), 32'd0);
        chk("en_rsp", 32'(rlog.size() - r0), 32'd2);
        chk("en_busy", 32'(busy), 32'd0);
        cfg_enable = 1'b1;
        drain();

        // Reset with two buffered and two in flight.
        v_valid       = '1;
        bus.rsp_ready = 1'b0;
        apply();
        repeat (4) tick();
        reset = 1'b0;
        tick();
        chk("rst_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp", 32'({bus.dp_a, bus.dp_b, bus.dp_c}), 32'd0);
        reset = 1'b1;
        n0 = glog.size();
        tick();
        chk("rst_first", 32'(glog.size() > n0 ? glog[n0] : -1), 32'd0);
        drain();

        // Datapath arithmetic corners.
        bus.rsp_ready = 1'b0;
        v_valid       = 4'b0001;
        op_a[0] = 4'hF; op_b[0] = 4'h0; op_c[0] = 4'hA;
        apply();
        tick();
        op_a[0] = 4'hF; op_b[0] = 4'hF; op_c[0] = 4'hF;
        apply();
        tick();
        v_valid = '0;
        apply();
        repeat (3) tick();
        r0            = rlog.size();
        bus.rsp_ready = 1'b1;
        repeat (3) tick();
        chk("m_cnt", 32'(rlog.size() - r0), 32'd2);
        if (rlog.size() - r0 >= 2) begin
            chk("m1_and", 32'(rlog[r0].andv), 32'hA);
            chk("m1_a", 32'(rlog[r0].a), 32'hF);
            chk("m1_b", 32'(rlog[r0].b), 32'h0);
            chk("m2_and", 32'(rlog[r0+1].andv), 32'h0);
            chk("m2_a", 32'(rlog[r0+1].a), 32'hF);
            chk("m2_b", 32'(rlog[r0+1].b), 32'hF);
        end

        // Random traffic, including occasional resets and mask/enable changes.
        for (int i = 0; i < 500; i++) begin
            rand_ops();
            v_valid       = NR'($urandom);
            cfg_mask      = ($urandom_range(0, 3) == 0) ? NR'($urandom) : '0;
            cfg_enable    = ($urandom_range(0, 7) != 0);
            bus.rsp_ready = 1'($urandom);
            reset         = ($urandom_range(0, 99) != 0);
            apply();
            tick();
        end
        reset      = 1'b1;
        cfg_enable = 1'b1;
        cfg_mask   = '0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
